// File: rtl/alu_sched.sv
// Shares one combinational ALU between NREQ requesters.
// Round-robin grant, three-cycle IDLE/EXEC/RESP sequence per op.
module alu_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_cs,
  input  logic [WIDTH-1:0]      alu_result,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] own;
  logic           bad;

  logic [IDW-1:0] win;
  logic           found;
  int             idx;
  logic           hs;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [2:0]     op_w;
  logic [2:0]     cs_w;
  logic           bad_w;

  // first pending requester at or after rr_ptr, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && j == idx && req_valid[j]) begin
          found = 1'b1;
          win   = IDW'(j);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = !rst && state == IDLE &&
                     found && win == IDW'(j);
    end
  end

  assign hs = |(req_valid & req_ready);

  always_comb begin
    a_w  = '0;
    b_w  = '0;
    op_w = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win == IDW'(j)) begin
        a_w  = req_a[j*WIDTH +: WIDTH];
        b_w  = req_b[j*WIDTH +: WIDTH];
        op_w = req_op[j*3 +: 3];
      end
    end
  end

  // CMP runs as SUB; illegal ops park the ALU on AND
  always_comb begin
    bad_w = op_w > 3'b100;
    if (op_w == 3'b100) cs_w = 3'b011;
    else if (bad_w)     cs_w = 3'b000;
    else                cs_w = op_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      own         <= '0;
      bad         <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cs      <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      resp_id     <= '0;
      busy        <= 1'b0;
    end else begin
      resp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            alu_a  <= a_w;
            alu_b  <= b_w;
            alu_cs <= cs_w;
            bad    <= bad_w;
            own    <= win;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= bad ? '0 : alu_result;
          resp_zero   <= bad | ~|alu_result;
          resp_err    <= bad;
          resp_id     <= own;
          for (int j = 0; j < NREQ; j++) begin
            resp_valid[j] <= own == IDW'(j);
          end
          state <= RESP;
        end
        RESP: begin
          rr_ptr <= (own == IDW'(NREQ-1)) ? '0 : own + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized bench for alu_sched with a transaction-level
// scoreboard derived from the grant/latency/arithmetic rules.
module tb_alu_sched;
  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [2:0]        alu_cs;
  logic [W-1:0]      alu_result;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_result;
  logic              resp_zero;
  logic              resp_err;
  logic [IDW-1:0]    resp_id;
  logic              busy;

  logic [W-1:0]    ra [NREQ];
  logic [W-1:0]    rb [NREQ];
  logic [2:0]      rop[NREQ];
  logic [NREQ-1:0] rv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sched #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cs(alu_cs),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_err(resp_err),
    .resp_id(resp_id), .busy(busy)
  );

  // the shared ALU itself
  always_comb begin
    alu_result = '0;
    case (alu_cs)
      3'd0: alu_result = alu_a & alu_b;
      3'd1: alu_result = alu_a | alu_b;
      3'd2: alu_result = alu_a + alu_b;
      3'd3: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_valid = rv;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
      req_op[i*3 +: 3] = rop[i];
    end
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(logic [2:0] op,
                                           logic [W-1:0] a,
                                           logic [W-1:0] b);
    case (op)
      3'd0:       return a & b;
      3'd1:       return a | b;
      3'd2:       return a + b;
      3'd3, 3'd4: return a - b;
      default:    return '0;
    endcase
  endfunction

  function automatic logic [2:0] ref_cs(logic [2:0] op);
    if (op == 3'd4) return 3'd3;
    if (op > 3'd4)  return 3'd0;
    return op;
  endfunction

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0] op;
    int         c;
  } txn_t;

  txn_t q[$];
  int cyc = 0;
  int next_free = 0;
  int ptr = 0;

  // scoreboard: accepted at c, ALU busy at c+1, response at c+2
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    logic [W-1:0]    r;
    logic            eb;
    int              idx;
    txn_t            t;
    cyc++;
    if (rst) begin
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      q.delete();
      ptr = 0;
      next_free = 0;
    end else begin
      eb = q.size() > 0 && cyc > q[0].c;
      check("busy", 64'(busy), 64'(eb));
      if (q.size() > 0 && cyc == q[0].c + 1) begin
        check("alu_a", 64'(alu_a), 64'(q[0].a));
        check("alu_b", 64'(alu_b), 64'(q[0].b));
        check("alu_cs", 64'(alu_cs), 64'(ref_cs(q[0].op)));
      end
      ev = '0;
      if (q.size() > 0 && cyc == q[0].c + 2) begin
        t  = q.pop_front();
        ev = NREQ'(1) << t.id;
        r  = ref_res(t.op, t.a, t.b);
        check("resp_result", 64'(resp_result), 64'(r));
        check("resp_zero", 64'(resp_zero), 64'(r == '0));
        check("resp_err", 64'(resp_err), 64'(t.op > 3'd4));
        check("resp_id", 64'(resp_id), 64'(t.id));
      end
      check("resp_valid", 64'(resp_valid), 64'(ev));
      er = '0;
      if (cyc >= next_free) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr + k) % NREQ;
          if (er == '0 && |(rv & (NREQ'(1) << idx)))
            er = NREQ'(1) << idx;
        end
      end
      check("req_ready", 64'(req_ready), 64'(er));
      if ((er & rv) != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (er[k]) begin
            t.id = k; t.a = ra[k]; t.b = rb[k];
            t.op = rop[k]; t.c = cyc;
            q.push_back(t);
            ptr = (k + 1) % NREQ;
          end
        end
        next_free = cyc + 3;
      end
    end
  end

  task automatic run_one(int i, logic [W-1:0] a, logic [W-1:0] b,
                         logic [2:0] op, logic [W-1:0] er,
                         logic ez, logic ee);
    int n;
    ra[i] = a; rb[i] = b; rop[i] = op; rv[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 10);
    check("dir_ready", 64'(req_ready), 64'(NREQ'(1) << i));
    @(posedge clk);
    #1 rv[i] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid == '0 && n < 5);
    check("dir_latency", 64'(n), 64'(2));
    check("dir_valid", 64'(resp_valid), 64'(NREQ'(1) << i));
    check("dir_result", 64'(resp_result), 64'(er));
    check("dir_zero", 64'(resp_zero), 64'(ez));
    check("dir_err", 64'(resp_err), 64'(ee));
    check("dir_id", 64'(resp_id), 64'(i));
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(int i);
    int r;
    r = $urandom_range(0, 3);
    ra[i] = (r == 0) ? '0 : (r == 1) ? '1 : W'($urandom);
    r = $urandom_range(0, 3);
    rb[i] = (r == 0) ? ra[i] : (r == 1) ? W'(1) : W'($urandom);
    rop[i] = 3'($urandom_range(0, 7));
    rv[i] = 1'b1;
  endtask

  initial begin
    int g[$];
    int n;
    logic [NREQ-1:0] hs;
    rst = 1'b1;
    rv  = '0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_one(0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1'b0);
    run_one(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b100, 32'd0, 1'b1, 1'b0);
    run_one(0, 32'd0, 32'd1, 3'b011, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_one(1, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 1'b1, 1'b0);
    run_one(0, 32'h1234, 32'h5678, 3'b111, 32'd0, 1'b1, 1'b1);

    // reset in the middle of EXEC
    ra[0] = 32'd3; rb[0] = 32'd4; rop[0] = 3'b010; rv[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[0] && n < 10);
    check("mid_ready", 64'(req_ready[0]), 64'(1));
    @(posedge clk);
    #1 rv = '0;
    #2 rst = 1'b1;
    #1;
    check("mid_alu_a", 64'(alu_a), 64'(0));
    check("mid_alu_b", 64'(alu_b), 64'(0));
    check("mid_alu_cs", 64'(alu_cs), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_result", 64'(resp_result), 64'(0));
    check("mid_zero", 64'(resp_zero), 64'(0));
    check("mid_id", 64'(resp_id), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rv = '1;
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready), 64'(1));
    check("post_rst_noresp", 64'(resp_valid), 64'(0));
    @(posedge clk);
    #1 rv = '0;
    repeat (4) @(posedge clk);

    // both held valid for 12 cycles after reset
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    new_req(0);
    new_req(1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) if (hs[i]) g.push_back(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) new_req(i);
    end
    check("alt_count", 64'(g.size()), 64'(4));
    for (int k = 0; k < g.size(); k++) check("alt_order", 64'(g[k]), 64'(k % 2));
    rv = '0;
    repeat (3) @(posedge clk);
    #1;

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rv[i]) begin
          if (hs[i] || $urandom_range(0, 15) == 0) rv[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
    end
    rv = '0;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
